// File: rtl/spi_regmap_pkg.sv
// ---------------------------------------------------------------------------
// spi_regmap_pkg
// Shared definitions for the burst-capable SPI register map:
//   state_t  - frame state machine encoding (IDLE / CMD / DATA)
//   RW_*     - value of the first frame bit for write and read
//   cmdLen() - number of command bits in a frame (R/W bit + address)
// ---------------------------------------------------------------------------
package spi_regmap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  function automatic int cmdLen(input int addrWidth);
    return 1 + addrWidth;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchroniser for one asynchronous pin followed by a rise/fall
// pulse detector. A pin edge shows up as a one-clk pulse two clocks later,
// so logic acting on the pulse changes state on the third clock.
// Ports:
//   clk, rst_n - system clock, async active-low reset
//   i_async    - asynchronous input pin
//   o_sync     - synchronised level
//   o_rise     - one-clk pulse on a synchronised rising edge
//   o_fall     - one-clk pulse on a synchronised falling edge
// ---------------------------------------------------------------------------
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // All stages reset low: a pin that is already low when reset releases
  // never produces a false fall pulse, so a frame interrupted by reset is
  // only picked up again on the next genuine cs falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_regmap_burst.sv
// ---------------------------------------------------------------------------
// spi_regmap_burst
// SPI mode-0 slave register map with burst access. A frame is one R/W bit,
// ADDR_WIDTH address bits, then any number of DATA_WIDTH words (all MSB
// first); the address auto-increments per word and wraps at 2^ADDR_WIDTH.
// Addresses 0..NUM_CFG-1 are read/write config flops, the next NUM_STS
// addresses read the live sts_i words, anything above reads as zero.
// Ports:
//   clk, rst_n           - system clock, async active-low reset
//   sck_i, sdi_i, cs_ni  - SPI pins (asynchronous to clk)
//   sdo_o, sdo_oe_o      - SPI read data and its drive enable
//   cfg_o                - flattened config registers, word k at [k*DW +: DW]
//   sts_i                - flattened status words, same packing
//   wr_stb_o, wr_addr_o  - one-clk pulse and address per committed write
// ---------------------------------------------------------------------------
module spi_regmap_burst
  import spi_regmap_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CFG    = 96,
  parameter int NUM_STS    = 32,
  parameter logic [DATA_WIDTH-1:0] CFG_RST_VAL = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sck_i,
  input  logic                            sdi_i,
  input  logic                            cs_ni,
  output logic                            sdo_o,
  output logic                            sdo_oe_o,
  output logic [NUM_CFG*DATA_WIDTH-1:0]   cfg_o,
  input  logic [NUM_STS*DATA_WIDTH-1:0]   sts_i,
  output logic                            wr_stb_o,
  output logic [ADDR_WIDTH-1:0]           wr_addr_o
);

  localparam int CMD_LEN = cmdLen(ADDR_WIDTH);
  localparam int CNT_W   = $clog2((CMD_LEN > DATA_WIDTH) ? CMD_LEN : DATA_WIDTH);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  logic w_sckSync, w_sckRise, w_sckFall;
  logic w_csSync, w_csRise, w_csFall;

  spi_sync_edge u_sckSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (sck_i),
    .o_sync  (w_sckSync),
    .o_rise  (w_sckRise),
    .o_fall  (w_sckFall)
  );

  spi_sync_edge u_csSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (cs_ni),
    .o_sync  (w_csSync),
    .o_rise  (w_csRise),
    .o_fall  (w_csFall)
  );

  state_t                          r_state;
  logic [CNT_W-1:0]                r_bitCnt;
  logic [ADDR_WIDTH-1:0]           r_cmdSr;
  logic                            r_rw;
  logic [ADDR_WIDTH-1:0]           r_addr;
  logic [DATA_WIDTH-2:0]           r_rxSr;
  logic [DATA_WIDTH-1:0]           r_txSr;
  logic [NUM_CFG*DATA_WIDTH-1:0]   r_cfg;
  logic                            r_wrStb;
  logic [ADDR_WIDTH-1:0]           r_wrAddr;
  logic                            r_sdiMeta;
  logic                            r_sdiSync;

  // The bit arriving on this sck rise completes the shift registers, so the
  // full command/word is formed combinationally from the stored bits + sdi.
  logic [CMD_LEN-1:0]    w_cmdNext;
  logic [DATA_WIDTH-1:0] w_rxWord;
  int                    w_addrInt;
  logic [DATA_WIDTH-1:0] w_rdData;
  logic                  w_oe;

  assign w_cmdNext = {r_cmdSr, r_sdiSync};
  assign w_rxWord  = {r_rxSr, r_sdiSync};
  assign w_addrInt = int'(r_addr);

  always_comb begin
    w_rdData = '0;
    if (w_addrInt < NUM_CFG) begin
      w_rdData = r_cfg[w_addrInt*DATA_WIDTH +: DATA_WIDTH];
    end else if (w_addrInt < NUM_CFG + NUM_STS) begin
      w_rdData = sts_i[(w_addrInt - NUM_CFG)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // sdi goes through the same two-flop delay as sck, so r_sdiSync is the
  // value that was on the pin when the detected sck edge happened.
  // cs high (edge or level) ends the frame and outranks any sck event in the
  // same clock, which is what discards a partially shifted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bitCnt  <= '0;
      r_cmdSr   <= '0;
      r_rw      <= RW_WRITE;
      r_addr    <= '0;
      r_rxSr    <= '0;
      r_txSr    <= '0;
      r_cfg     <= {NUM_CFG{CFG_RST_VAL}};
      r_wrStb   <= 1'b0;
      r_wrAddr  <= '0;
      r_sdiMeta <= 1'b0;
      r_sdiSync <= 1'b0;
    end else begin
      r_sdiMeta <= sdi_i;
      r_sdiSync <= r_sdiMeta;
      r_wrStb   <= 1'b0;
      if (r_state != ST_IDLE && (w_csRise || w_csSync)) begin
        r_state  <= ST_IDLE;
        r_bitCnt <= '0;
        r_txSr   <= '0;
      end else begin
        case (r_state)
          // A frame only starts with sck at its mode-0 idle level, so a
          // glitchy start cannot misalign the command bits.
          ST_IDLE: begin
            if (w_csFall && !w_sckSync) begin
              r_state  <= ST_CMD;
              r_bitCnt <= '0;
            end
          end
          ST_CMD: begin
            if (w_sckRise) begin
              if (r_bitCnt == CMD_LAST) begin
                r_rw     <= w_cmdNext[CMD_LEN-1];
                r_addr   <= w_cmdNext[ADDR_WIDTH-1:0];
                r_bitCnt <= '0;
                r_state  <= ST_DATA;
              end else begin
                r_cmdSr  <= w_cmdNext[ADDR_WIDTH-1:0];
                r_bitCnt <= r_bitCnt + CNT_W'(1);
              end
            end
          end
          ST_DATA: begin
            if (w_sckRise) begin
              r_rxSr <= w_rxWord[DATA_WIDTH-2:0];
              if (r_bitCnt == DATA_LAST) begin
                if (r_rw == RW_WRITE && w_addrInt < NUM_CFG) begin
                  r_cfg[w_addrInt*DATA_WIDTH +: DATA_WIDTH] <= w_rxWord;
                  r_wrStb  <= 1'b1;
                  r_wrAddr <= r_addr;
                end
                r_addr   <= r_addr + ADDR_WIDTH'(1);
                r_bitCnt <= '0;
              end else begin
                r_bitCnt <= r_bitCnt + CNT_W'(1);
              end
            end else if (w_sckFall && r_rw == RW_READ) begin
              // A zero count means no bit of the current word has been
              // sampled yet: this is the word's first falling edge.
              if (r_bitCnt == '0) begin
                r_txSr <= w_rdData;
              end else begin
                r_txSr <= {r_txSr[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_oe      = (r_state == ST_DATA) && (r_rw == RW_READ) && !w_csSync;
  assign sdo_oe_o  = w_oe;
  assign sdo_o     = w_oe & r_txSr[DATA_WIDTH-1];
  assign cfg_o     = r_cfg;
  assign wr_stb_o  = r_wrStb;
  assign wr_addr_o = r_wrAddr;

endmodule
